out_signature_monitor: RTL

Downstream response compactor for the `tt_um_verilog_testing` user project: samples the 8-bit `uo_out` bus over a programmed number of valid cycles, compacts it into a MISR signature and compares it against a golden value. It sits between the user project's dedicated outputs and the bench/on-chip test controller, so a long output stream reduces to one pass/fail bit plus a readable signature.

---
 rtl/out_signature_monitor.sv | 117 +++++++++++
 1 files changed

// File: rtl/out_signature_monitor.sv
// Output signature monitor: compacts uo_out samples into a Galois MISR and checks it against a golden value.
// Define SIGMON_ABORT_EN to add an abort input that ends a run early with pass forced low.
module out_signature_monitor #(
  parameter int               WIDTH = 8,
  parameter int               CNT_W = 16,
  parameter logic [WIDTH-1:0] POLY  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'hFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [WIDTH-1:0] golden,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
`ifdef SIGMON_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] misr_next;
  logic             start_ok;
  logic             abort_ok;
  logic             sample_ok;
  logic             last_sample;
  logic             busy_next;
  logic             done_next;

  assign start_ok = (state == IDLE) && start && ena;

`ifdef SIGMON_ABORT_EN
  assign abort_ok = (state == RUN) && ena && abort;
`else
  assign abort_ok = 1'b0;
`endif

  // An abort wins over a sample arriving in the same cycle, so that sample is dropped.
  assign sample_ok   = (state == RUN) && ena && data_valid && !abort_ok;
  assign last_sample = sample_ok && (remaining == CNT_W'(1));

  always_comb begin
    misr_next = (signature >> 1) ^ (signature[0] ? POLY : '0) ^ data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_next = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort_ok || last_sample) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state and registered, so they change only on clock edges.
  always_comb begin
    busy_next = (state_next == RUN);
    done_next = (state_next == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_next;
      done <= done_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      signature <= SEED;
      remaining <= '0;
      pass      <= 1'b0;
    end else if (start_ok) begin
      signature <= SEED;
      remaining <= len;
      pass      <= (len == '0) ? (SEED == golden) : 1'b0;
    end else if (abort_ok) begin
      pass <= 1'b0;
    end else if (sample_ok) begin
      signature <= misr_next;
      remaining <= remaining - CNT_W'(1);
      if (last_sample) begin
        pass <= (misr_next == golden);
      end
    end
  end

endmodule
